// File: rtl/line_mem_responder.sv
// Line-wide memory responder: accepts one line read or write request at a time,
// services it after a fixed latency and signals completion with a one-cycle grant.
module line_mem_responder #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int ADDR_LEN      = 9,
    parameter int LATENCY       = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_LEN-1:0] addr,
    input  logic                rd_req,
    input  logic                wr_req,
    input  logic [31:0]         wr_line [2**LINE_ADDR_LEN],
    output logic [31:0]         rd_line [2**LINE_ADDR_LEN],
    output logic                gnt,
    output logic                busy,
    output logic [15:0]         rd_cnt,
    output logic [15:0]         wr_cnt
);

    localparam int WORDS  = 2**LINE_ADDR_LEN;
    localparam int DEPTH  = 2**ADDR_LEN;
    localparam int LINE_W = WORDS * 32;
    localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_GRANT = 2'd2
    } state_t;

    state_t              state_r;
    logic [7:0]          cnt_r;
    logic [ADDR_LEN-1:0] addr_r;
    logic                op_wr_r;
    logic [LINE_W-1:0]   wr_data_r;
    logic [LINE_W-1:0]   wr_pack_s;
    logic                access_s;
    logic                commit_wr_s;
    logic                commit_rd_s;

    // Storage is deliberately outside the reset domain so a reset never erases it.
    logic [LINE_W-1:0]   mem_r [DEPTH] = '{default: '0};

    // Pack the incoming word array into one flat line for latching.
    always_comb begin
        wr_pack_s = '0;
        for (int i = 0; i < WORDS; i++) begin
            wr_pack_s[i*32 +: 32] = wr_line[i];
        end
    end

    // The access happens on the last BUSY edge; reads and writes are mutually exclusive.
    always_comb begin
        access_s    = 1'b0;
        commit_wr_s = 1'b0;
        commit_rd_s = 1'b0;
        if (state_r == ST_BUSY && cnt_r == 8'd0) begin
            access_s    = 1'b1;
            commit_wr_s = op_wr_r;
            commit_rd_s = !op_wr_r;
        end else begin
            access_s    = 1'b0;
            commit_wr_s = 1'b0;
            commit_rd_s = 1'b0;
        end
    end

    // Request FSM with registered gnt/busy and saturating completion counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 8'd0;
            addr_r    <= '0;
            op_wr_r   <= 1'b0;
            wr_data_r <= '0;
            gnt       <= 1'b0;
            busy      <= 1'b0;
            rd_cnt    <= 16'd0;
            wr_cnt    <= 16'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    gnt <= 1'b0;
                    if (wr_req || rd_req) begin
                        // A simultaneous write wins; a held read is taken after its grant.
                        addr_r    <= addr;
                        op_wr_r   <= wr_req;
                        wr_data_r <= wr_pack_s;
                        cnt_r     <= CNT_LOAD;
                        state_r   <= ST_BUSY;
                        busy      <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    if (access_s) begin
                        state_r <= ST_GRANT;
                        busy    <= 1'b0;
                        gnt     <= 1'b1;
                        if (op_wr_r) begin
                            if (wr_cnt != 16'hFFFF) begin
                                wr_cnt <= wr_cnt + 16'd1;
                            end
                        end else begin
                            if (rd_cnt != 16'hFFFF) begin
                                rd_cnt <= rd_cnt + 16'd1;
                            end
                        end
                    end else begin
                        cnt_r <= cnt_r - 8'd1;
                        busy  <= 1'b1;
                        gnt   <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    state_r <= ST_IDLE;
                    gnt     <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    gnt     <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Line write into storage at the completing edge.
    always_ff @(posedge clk) begin
        if (commit_wr_s) begin
            mem_r[addr_r] <= wr_data_r;
        end
    end

    // Read data register; only a completing read updates it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WORDS; i++) begin
                rd_line[i] <= 32'd0;
            end
        end else if (commit_rd_s) begin
            for (int i = 0; i < WORDS; i++) begin
                rd_line[i] <= mem_r[addr_r][i*32 +: 32];
            end
        end
    end

endmodule
